// File: rtl/ws2812_frame_scheduler.sv
// ws2812_frame_scheduler
//   Frame sequencer for the WS2812 line transmitter. Holds a double-buffered 24-bit pixel store.
//   It restarts the transmitter once per frame period. Host commits swap the banks atomically at
//   the next frame start.
// Ports
//   clk, rst         system clock; synchronous active-low reset
//   en               run frames (0: finish current frame, then idle)
//   wr_en/addr/data  host write port into the back bank
//   commit           pulse: back bank complete, swap at next frame start
//   commit_count     pixel count of the committed frame, sampled with commit
//   commit_ack       pulse in the swap cycle
//   busy             transmitter being restarted or sending
//   overrun          sticky: frame tick arrived while a frame was still going out
//   frame_cnt        frames started (wraps)
//   lt_rst           active-high reset to the line transmitter
//   lt_pixel_count   pixel count of the current frame
//   lt_address       read address from the transmitter
//   lt_pixel         front-bank pixel at lt_address (combinational)
//   lt_done          transmitter finished (level)
module ws2812_frame_scheduler #(
  parameter int unsigned ADD_WIDTH    = 8,
  parameter int unsigned FRAME_CLKS   = 833333,
  parameter int unsigned START_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 wr_en,
  input  logic [ADD_WIDTH-1:0] wr_addr,
  input  logic [23:0]          wr_data,
  input  logic                 commit,
  input  logic [ADD_WIDTH:0]   commit_count,
  output logic                 commit_ack,
  output logic                 busy,
  output logic                 overrun,
  output logic [15:0]          frame_cnt,
  output logic                 lt_rst,
  output logic [ADD_WIDTH:0]   lt_pixel_count,
  input  logic [ADD_WIDTH-1:0] lt_address,
  output logic [23:0]          lt_pixel,
  input  logic                 lt_done
);

  localparam int unsigned Depth  = 2 ** ADD_WIDTH;
  localparam int unsigned TimerW = (FRAME_CLKS > 2) ? $clog2(FRAME_CLKS) : 1;
  localparam int unsigned StartW = $clog2(START_CYCLES + 1);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(FRAME_CLKS - 1);
  localparam logic [StartW-1:0] StartLast = StartW'(START_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StFrameBegin, StStart, StSend, StWait} state_e;

  state_e              state_q, state_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [StartW-1:0]   start_cnt_q, start_cnt_d;
  logic                bank_sel_q, bank_sel_d;
  logic                pending_q, pending_d;
  logic [ADD_WIDTH:0]  count_hold_q, count_hold_d;
  logic [ADD_WIDTH:0]  pix_count_q, pix_count_d;
  logic                tick_pending_q, tick_pending_d;
  logic                overrun_q, overrun_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic                first_send_q, first_send_d;
  logic                tick;
  logic [ADD_WIDTH:0]  eff_count;

  // Both banks in one array; the MSB of the index selects the bank.
  logic [23:0] mem [2*Depth];

  // Back-bank writes decode on the registered bank_sel, so a write in the swap cycle lands in
  // the bank that is becoming front.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{~bank_sel_q, wr_addr}] <= wr_data;
    end
  end

  assign lt_pixel       = mem[{bank_sel_q, lt_address}];
  assign overrun        = overrun_q;
  assign frame_cnt      = frame_cnt_q;
  assign lt_pixel_count = pix_count_q;

  always_comb begin
    state_d        = state_q;
    start_cnt_d    = start_cnt_q;
    bank_sel_d     = bank_sel_q;
    pending_d      = pending_q;
    count_hold_d   = count_hold_q;
    pix_count_d    = pix_count_q;
    tick_pending_d = tick_pending_q;
    overrun_d      = overrun_q;
    frame_cnt_d    = frame_cnt_q;
    commit_ack     = 1'b0;
    busy           = 1'b0;
    lt_rst         = 1'b1;
    tick           = (state_q != StIdle) && (timer_q == TimerLast);
    eff_count      = pending_q ? count_hold_q : pix_count_q;
    // START starts SEND, so "previous state was START" marks the first SEND cycle.
    first_send_d   = (state_q == StStart);

    // A tick mid-frame is remembered; the frame itself is never cut short.
    if ((state_q == StStart || state_q == StSend) && tick) begin
      overrun_d      = 1'b1;
      tick_pending_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        tick_pending_d = 1'b0;
        if (en) state_d = StFrameBegin;
      end
      StFrameBegin: begin
        if (pending_q) begin
          bank_sel_d  = ~bank_sel_q;
          pix_count_d = count_hold_q;
          pending_d   = 1'b0;
          commit_ack  = 1'b1;
        end
        if (eff_count == '0) begin
          state_d = StWait;
        end else begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          start_cnt_d = '0;
          state_d     = StStart;
        end
      end
      StStart: begin
        busy = 1'b1;
        if (start_cnt_q == StartLast) state_d = StSend;
        else start_cnt_d = start_cnt_q + StartW'(1);
      end
      StSend: begin
        busy   = 1'b1;
        lt_rst = 1'b0;
        // lt_done may still reflect the previous frame on the first cycle.
        if (lt_done && !first_send_q) begin
          tick_pending_d = 1'b0;
          if (!en) state_d = StIdle;
          else if (tick_pending_q || tick) state_d = StFrameBegin;
          else state_d = StWait;
        end
      end
      StWait: begin
        if (tick) state_d = en ? StFrameBegin : StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A commit coinciding with a swap queues up for the following frame.
    if (commit) begin
      pending_d    = 1'b1;
      count_hold_d = commit_count;
    end

    if (state_q == StIdle || state_d == StIdle || tick) timer_d = '0;
    else timer_d = timer_q + TimerW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= StIdle;
      timer_q        <= '0;
      start_cnt_q    <= '0;
      bank_sel_q     <= 1'b0;
      pending_q      <= 1'b0;
      count_hold_q   <= '0;
      pix_count_q    <= '0;
      tick_pending_q <= 1'b0;
      overrun_q      <= 1'b0;
      frame_cnt_q    <= '0;
      first_send_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      start_cnt_q    <= start_cnt_d;
      bank_sel_q     <= bank_sel_d;
      pending_q      <= pending_d;
      count_hold_q   <= count_hold_d;
      pix_count_q    <= pix_count_d;
      tick_pending_q <= tick_pending_d;
      overrun_q      <= overrun_d;
      frame_cnt_q    <= frame_cnt_d;
      first_send_q   <= first_send_d;
    end
  end

endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// Bench for ws2812_frame_scheduler.
// Contains a behavioural line-transmitter model and a pixel scoreboard.
// The sequence of directed steps runs in one initial block.
module tb_ws2812_frame_scheduler;

  localparam int AW = 4;
  localparam int FC = 200;
  localparam int SC = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [23:0]   wr_data = '0;
  logic          commit = 1'b0;
  logic [AW:0]   commit_count = '0;
  logic          commit_ack;
  logic          busy;
  logic          overrun;
  logic [15:0]   frame_cnt;
  logic          lt_rst;
  logic [AW:0]   lt_pixel_count;
  logic [AW-1:0] lt_address = '0;
  logic [23:0]   lt_pixel;
  logic          lt_done = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [23:0] exp_q[$];
  logic mon_on = 1'b0;
  int pix_clks = 4;
  int m_cnt = 0;
  int m_pix = 0;

  ws2812_frame_scheduler #(
    .ADD_WIDTH   (AW),
    .FRAME_CLKS  (FC),
    .START_CYCLES(SC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .commit        (commit),
    .commit_count  (commit_count),
    .commit_ack    (commit_ack),
    .busy          (busy),
    .overrun       (overrun),
    .frame_cnt     (frame_cnt),
    .lt_rst        (lt_rst),
    .lt_pixel_count(lt_pixel_count),
    .lt_address    (lt_address),
    .lt_pixel      (lt_pixel),
    .lt_done       (lt_done)
  );

  always #5 clk = ~clk;

  // Line transmitter: pix_clks cycles per pixel, then lt_done until restarted.
  always @(posedge clk) begin
    if (lt_rst) begin
      m_cnt      <= 0;
      m_pix      <= 0;
      lt_address <= '0;
      lt_done    <= 1'b0;
    end else if (!lt_done) begin
      if (m_cnt == pix_clks - 1) begin
        m_cnt <= 0;
        if (m_pix + 1 >= int'(lt_pixel_count)) begin
          lt_done <= 1'b1;
        end else begin
          m_pix      <= m_pix + 1;
          lt_address <= lt_address + 4'd1;
        end
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pixel scoreboard: each pixel the transmitter latches is checked against the queue.
  always @(negedge clk) begin
    if (mon_on && !lt_rst && !lt_done && m_cnt == 0) begin
      if (exp_q.size() == 0) begin
        check("pixel_extra", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        check("pixel", 32'(lt_pixel), 32'(e));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [AW-1:0] a, input logic [23:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_commit(input logic [AW:0] n);
    commit = 1'b1; commit_count = n;
    @(negedge clk);
    commit = 1'b0;
  endtask

  task automatic push4(input logic [23:0] a, input logic [23:0] b,
                       input logic [23:0] c, input logic [23:0] d);
    exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c); exp_q.push_back(d);
    mon_on = 1'b1;
  endtask

  // Waits for the next frame to start sending, then for it to finish.
  task automatic wait_frame(input string tag);
    int t;
    t = 0;
    while (!(!lt_rst && !lt_done) && t < 2000) begin @(negedge clk); t++; end
    while (!lt_done && t < 2000) begin @(negedge clk); t++; end
    check({tag, "_done"}, 32'(lt_done), 32'd1);
    mon_on = 1'b0;
    check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_ack(input string tag);
    int t;
    t = 0;
    while (!commit_ack && t < 500) begin @(negedge clk); t++; end
    check(tag, 32'(commit_ack), 32'd1);
  endtask

  task automatic wait_send();
    int t;
    t = 0;
    while (!(busy && !lt_rst) && t < 500) begin @(negedge clk); t++; end
    check("reach_send", 32'(busy && !lt_rst), 32'd1);
  endtask

  initial begin
    int t;
    int busy_cnt;
    logic [15:0] fc;

    // Reset, idle.
    repeat (2) @(negedge clk);
    check("rst_lt_rst", 32'(lt_rst), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_ack", 32'(commit_ack), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_pix_count", 32'(lt_pixel_count), 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // First frame.
    wr(4'd0, 24'hAAAAAA); wr(4'd1, 24'hFFFFFF); wr(4'd2, 24'hAAAAAA); wr(4'd3, 24'h000000);
    do_commit(5'd4);
    push4(24'hAAAAAA, 24'hFFFFFF, 24'hAAAAAA, 24'h000000);
    en = 1'b1;
    wait_ack("f1_ack");
    @(negedge clk);
    check("f1_ack_pulse", 32'(commit_ack), 32'd0);
    check("f1_pix_count", 32'(lt_pixel_count), 32'd4);
    check("f1_frame_cnt", 32'(frame_cnt), 32'd1);
    check("f1_busy", 32'(busy), 32'd1);
    wait_frame("f1");

    // Frame period.
    t = 0;
    while (frame_cnt != 16'd2 && t < 500) begin @(negedge clk); t++; end
    check("f2_start", 32'(frame_cnt), 32'd2);
    t = 0;
    while (frame_cnt != 16'd3 && t < 500) begin @(negedge clk); t++; end
    check("period", 32'(t), 32'(FC));
    check("no_overrun", 32'(overrun), 32'd0);

    // Back-bank writes mid-frame must not disturb the displayed bank.
    wait_send();
    wr(4'd0, 24'h123456); wr(4'd1, 24'h654321); wr(4'd2, 24'h0F0F0F); wr(4'd3, 24'hF0F0F0);
    t = 0;
    while (!lt_done && t < 500) begin @(negedge clk); t++; end
    push4(24'hAAAAAA, 24'hFFFFFF, 24'hAAAAAA, 24'h000000);
    wait_frame("unchanged");

    do_commit(5'd4);
    push4(24'h123456, 24'h654321, 24'h0F0F0F, 24'hF0F0F0);
    fc = frame_cnt;
    wait_ack("swap_ack");
    @(negedge clk);
    check("swap_frame_cnt", 32'(frame_cnt), 32'(fc + 16'd1));
    wait_frame("swapped");

    // Zero-length commit: swap without a frame.
    do_commit(5'd0);
    fc = frame_cnt;
    wait_ack("zero_ack");
    @(negedge clk);
    check("zero_pix_count", 32'(lt_pixel_count), 32'd0);
    busy_cnt = 0;
    repeat (250) begin @(negedge clk); if (busy) busy_cnt++; end
    check("zero_no_start", 32'(busy_cnt), 32'd0);
    check("zero_frame_cnt", 32'(frame_cnt), 32'(fc));

    // Old front bank (with the 0x123456 set) comes back on the next swap.
    do_commit(5'd4);
    push4(24'h123456, 24'h654321, 24'h0F0F0F, 24'hF0F0F0);
    wait_frame("restored");

    // Frame longer than the period: overrun, back-to-back restart.
    pix_clks = 16;
    for (int i = 0; i < 16; i++) wr(4'(i), 24'(i * 24'h010101));
    do_commit(5'd16);
    t = 0;
    while (!overrun && t < 1500) begin @(negedge clk); t++; end
    check("overrun_set", 32'(overrun), 32'd1);
    t = 0;
    while (!lt_done && t < 600) begin @(negedge clk); t++; end
    check("ovr_done", 32'(lt_done), 32'd1);
    fc = frame_cnt;
    @(negedge clk);
    check("ovr_fb_busy", 32'(busy), 32'd0);
    check("ovr_fb_lt_rst", 32'(lt_rst), 32'd1);
    @(negedge clk);
    check("ovr_restart_busy", 32'(busy), 32'd1);
    check("ovr_restart_cnt", 32'(frame_cnt), 32'(fc + 16'd1));
    check("overrun_sticky", 32'(overrun), 32'd1);

    // en dropped mid-SEND: frame completes, then idle for good.
    wait_send();
    en = 1'b0;
    t = 0;
    while (!lt_done && t < 600) begin @(negedge clk); t++; end
    check("en0_done", 32'(lt_done), 32'd1);
    check("en0_busy_until_done", 32'(busy), 32'd1);
    fc = frame_cnt;
    @(negedge clk);
    check("en0_idle", 32'(busy), 32'd0);
    busy_cnt = 0;
    repeat (300) begin @(negedge clk); if (busy) busy_cnt++; end
    check("en0_stays_idle", 32'(busy_cnt), 32'd0);
    check("en0_frame_cnt", 32'(frame_cnt), 32'(fc));

    // Reset mid-SEND.
    en = 1'b1;
    wait_send();
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_lt_rst", 32'(lt_rst), 32'd1);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("mrst_overrun", 32'(overrun), 32'd0);
    check("mrst_pix_count", 32'(lt_pixel_count), 32'd0);
    rst = 1'b1;
    en = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
